mem_port_arbiter: RTL

Shares the core's single-port data/instruction RAM between the instruction-fetch requester (read-only) and the memory-access stage (load/store). It sequences each access, converts sb/sh into read-modify-write pairs, aligns load data to bit 0 for the MEM stage's sign/zero extension, flags misaligned accesses, and arbitrates fairly under contention. It sits between the pipeline stages and the RAM macro, and it raises the pipeline `stop` condition while any request is outstanding.

---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Purpose : groups the fetch, MEM-stage and RAM-macro signals of mem_port_arbiter.
// Latency : none; wires only.
// Backpressure: requesters hold *_req until the matching one-cycle *_ack pulse.
//
// Ports (seen from the arbiter, modport slave):
//   if_req/if_addr -> in, if_rdata/if_ack -> out                         fetch side
//   mem_req/mem_we/mem_funct3/mem_addr/mem_wdata -> in,
//   mem_rdata/mem_ack/mem_misalign -> out                                MEM side
//   stall -> out                                                         pipeline stop
//   ram_en/ram_we/ram_addr/ram_wdata -> out, ram_rdata -> in             RAM macro
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;

  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_misalign;

  logic        stall;

  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  // Pipeline stages plus RAM macro.
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_funct3, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_ack, mem_rdata, mem_ack, mem_misalign, stall,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

  // The arbiter itself.
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_funct3, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_ack, mem_rdata, mem_ack, mem_misalign, stall,
    output ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-port RAM between instruction fetch and the MEM stage (sb/sh as RMW).
// Latency : ack 1 cycle after acceptance for reads, sw and misaligned; 2 cycles for sb/sh.
// Backpressure: requests are held until ack; stall is high while either request is unacknowledged.
//
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset; forces every output to 0 while low
//   bus   - mem_port_arbiter_if.slave (fetch, MEM-stage and RAM-macro signals)
module mem_port_arbiter (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, RMW, ST_ACK} state_t;
  typedef enum logic {GRANT_IF, GRANT_MEM} grant_t;

  state_t      state_q, state_d;
  grant_t      last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic        rmw_byte_q, rmw_byte_d;   // 1: sb lane merge, 0: sh lane merge
  logic [15:0] wdata_q, wdata_d;         // only the sub-word store data is needed after IDLE
  logic        mis_q, mis_d;

  logic        mem_is_byte, mem_is_half, mem_is_word, mem_misal;
  logic        grant_mem, grant_if;
  logic [31:0] rmw_word;

  logic        if_ack_c, mem_ack_c, mis_c, ram_en_c, ram_we_c;
  logic [31:0] if_rdata_c, mem_rdata_c, ram_addr_c, ram_wdata_c;

  // Access width from funct3; the unused codes 011/110/111 behave as word.
  assign mem_is_byte = (bus.mem_funct3 == 3'b000) || (bus.mem_funct3 == 3'b100);
  assign mem_is_half = (bus.mem_funct3 == 3'b001) || (bus.mem_funct3 == 3'b101);
  assign mem_is_word = ~mem_is_byte & ~mem_is_half;
  assign mem_misal   = (mem_is_half & bus.mem_addr[0]) |
                       (mem_is_word & (bus.mem_addr[1:0] != 2'b00));

  // Under contention the side that did not win last time goes first.
  assign grant_mem = bus.mem_req & (~bus.if_req | (last_grant_q == GRANT_IF));
  assign grant_if  = bus.if_req & ~grant_mem;

  // Store data merged into the word read back during the RMW read phase.
  always_comb begin
    rmw_word = bus.ram_rdata;
    if (rmw_byte_q) begin
      case (addr_q[1:0])
        2'd0: rmw_word[7:0]   = wdata_q[7:0];
        2'd1: rmw_word[15:8]  = wdata_q[7:0];
        2'd2: rmw_word[23:16] = wdata_q[7:0];
        2'd3: rmw_word[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      rmw_word[31:16] = wdata_q;
    end else begin
      rmw_word[15:0] = wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_IF;
      addr_q       <= '0;
      rmw_byte_q   <= 1'b0;
      wdata_q      <= '0;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      rmw_byte_q   <= rmw_byte_d;
      wdata_q      <= wdata_d;
      mis_q        <= mis_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    rmw_byte_d   = rmw_byte_q;
    wdata_d      = wdata_q;
    mis_d        = mis_q;
    if_ack_c     = 1'b0;
    if_rdata_c   = '0;
    mem_ack_c    = 1'b0;
    mem_rdata_c  = '0;
    mis_c        = 1'b0;
    ram_en_c     = 1'b0;
    ram_we_c     = 1'b0;
    ram_addr_c   = '0;
    ram_wdata_c  = '0;

    case (state_q)
      IDLE: begin
        if (grant_mem) begin
          last_grant_d = GRANT_MEM;
          addr_d       = bus.mem_addr;
          rmw_byte_d   = mem_is_byte;
          wdata_d      = bus.mem_wdata[15:0];
          if (mem_misal) begin
            // Rejected without touching the RAM; acked with the misalign flag.
            mis_d   = 1'b1;
            state_d = ST_ACK;
          end else begin
            ram_en_c   = 1'b1;
            ram_addr_c = {bus.mem_addr[31:2], 2'b00};
            if (!bus.mem_we) begin
              state_d = MEM_RD;
            end else if (mem_is_word) begin
              ram_we_c    = 1'b1;
              ram_wdata_c = bus.mem_wdata;
              state_d     = ST_ACK;
            end else begin
              // sb/sh: this strobe is the read half of the RMW pair.
              state_d = RMW;
            end
          end
        end else if (grant_if) begin
          last_grant_d = GRANT_IF;
          addr_d       = bus.if_addr;
          ram_en_c     = 1'b1;
          ram_addr_c   = {bus.if_addr[31:2], 2'b00};
          state_d      = IF_RD;
        end
      end
      IF_RD: begin
        if_ack_c   = 1'b1;
        if_rdata_c = bus.ram_rdata;
        state_d    = IDLE;
      end
      MEM_RD: begin
        // Addressed byte lands at bit 0; MEM stage does the sign/zero extension.
        mem_ack_c   = 1'b1;
        mem_rdata_c = bus.ram_rdata >> {addr_q[1:0], 3'b000};
        state_d     = IDLE;
      end
      RMW: begin
        ram_en_c    = 1'b1;
        ram_we_c    = 1'b1;
        ram_addr_c  = {addr_q[31:2], 2'b00};
        ram_wdata_c = rmw_word;
        state_d     = ST_ACK;
      end
      ST_ACK: begin
        mem_ack_c = 1'b1;
        mis_c     = mis_q;
        mis_d     = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are held at 0 while reset is asserted, including the IDLE-cycle
  // combinational RAM strobe that would otherwise follow the request inputs.
  assign bus.if_ack       = rst_n & if_ack_c;
  assign bus.if_rdata     = rst_n ? if_rdata_c  : '0;
  assign bus.mem_ack      = rst_n & mem_ack_c;
  assign bus.mem_rdata    = rst_n ? mem_rdata_c : '0;
  assign bus.mem_misalign = rst_n & mis_c;
  assign bus.ram_en       = rst_n & ram_en_c;
  assign bus.ram_we       = rst_n & ram_we_c;
  assign bus.ram_addr     = rst_n ? ram_addr_c  : '0;
  assign bus.ram_wdata    = rst_n ? ram_wdata_c : '0;
  assign bus.stall        = rst_n & ((bus.if_req & ~if_ack_c) | (bus.mem_req & ~mem_ack_c));

endmodule
